counter_updown_mod: RTL and testbench

COUNTER_UPDOWN_MOD -- requirements
Module: counter_updown_mod

---
 rtl/counter_pkg.sv | 19 +
 rtl/counter_prescaler.sv | 68 ++++++
 rtl/counter_updown_mod.sv | 153 +++++++++++++++
 tb/tb_counter_updown_mod.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared encodings for the up/down counter slice.
//   mode_e : counting behaviour at the range ends (wrap or saturate)
//   dir_e  : counting direction (down or up)
// ---------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler
// Produces a tick on every PRESCALE-th enabled cycle. The phase advances only
// while i_En is high and holds otherwise; i_Clr returns it to phase 0.
// Ports:
//   i_Clk   - clock, rising edge
//   i_nRst  - asynchronous active-low reset (phase -> 0)
//   i_Clr   - synchronous clear of the phase
//   i_En    - advance enable
//   o_Tick  - high in the enabled cycle that completes a prescale period
// With PRESCALE=1 there is no state and o_Tick simply follows i_En.
// ---------------------------------------------------------------------------
module counter_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic i_Clk,
    input  logic i_nRst,
    input  logic i_Clr,
    input  logic i_En,
    output logic o_Tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // Clock, reset and clear have no effect without phase state.
            logic unused_s;
            assign unused_s = i_Clk ^ i_nRst ^ i_Clr;
            assign o_Tick   = i_En;
        end else begin : g_div
            localparam int unsigned PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

            logic [PW-1:0] phase_r;
            logic [PW-1:0] phase_nxt_s;
            logic          tick_s;

            // Next phase and tick: clear wins, otherwise advance while enabled.
            always_comb begin
                phase_nxt_s = phase_r;
                tick_s      = 1'b0;
                if (i_Clr) begin
                    phase_nxt_s = PW'(0);
                end else if (i_En) begin
                    if (phase_r == LAST_PHASE) begin
                        phase_nxt_s = PW'(0);
                        tick_s      = 1'b1;
                    end else begin
                        phase_nxt_s = phase_r + PW'(1);
                    end
                end else begin
                    phase_nxt_s = phase_r;
                end
            end

            // Phase register; reset discards any partial prescale count.
            always_ff @(posedge i_Clk or negedge i_nRst) begin
                if (!i_nRst) begin
                    phase_r <= PW'(0);
                end else begin
                    phase_r <= phase_nxt_s;
                end
            end

            assign o_Tick = tick_s;
        end
    endgenerate

endmodule : counter_prescaler

// File: rtl/counter_updown_mod.sv
// ---------------------------------------------------------------------------
// counter_updown_mod
// Prescaled up/down counter over 0..MODULO-1 with wrap or saturate behaviour,
// synchronous clear and load, terminal-count indication and a sticky flag
// recording any wrap or saturation attempt.
// Ports:
//   i_Clk      - clock, rising edge
//   i_nRst     - asynchronous active-low reset
//   i_Clr      - synchronous clear of count and prescaler (highest priority)
//   i_En       - count enable (also advances the prescaler)
//   i_Up       - direction, 1 = up, 0 = down
//   i_Sat      - mode, 0 = wrap, 1 = saturate
//   i_Load     - synchronous load strobe
//   i_LoadVal  - load value, clamped to MODULO-1
//   i_OvfClr   - clears the sticky overflow flag
//   o_Cout     - registered count
//   o_Tc       - terminal count (combinational from o_Cout and i_Up)
//   o_Step     - one-cycle pulse in the cycle after each count step
//   o_Ovf      - sticky wrap/saturation flag
// ---------------------------------------------------------------------------
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULO   = 64'd1 << WIDTH,
    parameter int unsigned     PRESCALE = 1
) (
    input  logic             i_Clk,
    input  logic             i_nRst,
    input  logic             i_Clr,
    input  logic             i_En,
    input  logic             i_Up,
    input  logic             i_Sat,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_LoadVal,
    input  logic             i_OvfClr,
    output logic [WIDTH-1:0] o_Cout,
    output logic             o_Tc,
    output logic             o_Step,
    output logic             o_Ovf
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 64'd1);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] load_val_s;
    logic             step_r;
    logic             step_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic             tc_s;
    logic             tick_s;
    logic             pre_en_s;
    dir_e             dir_s;
    mode_e            mode_s;

    assign dir_s  = dir_e'(i_Up);
    assign mode_s = mode_e'(i_Sat);

    // A load cycle must leave the prescale phase untouched, so the prescaler
    // only sees the enable when no load is in progress.
    assign pre_en_s = i_En & ~i_Load;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_Clk  (i_Clk),
        .i_nRst (i_nRst),
        .i_Clr  (i_Clr),
        .i_En   (pre_en_s),
        .o_Tick (tick_s)
    );

    // Terminal count depends on the live direction input.
    always_comb begin
        tc_s = 1'b0;
        case (dir_s)
            DIR_UP:   tc_s = (cnt_r == MAX_CNT);
            DIR_DOWN: tc_s = (cnt_r == WIDTH'(0));
            default:  tc_s = 1'b0;
        endcase
    end

    // Load value clamp to the top of the count range.
    always_comb begin
        load_val_s = i_LoadVal;
        if (64'(i_LoadVal) >= MODULO) begin
            load_val_s = MAX_CNT;
        end else begin
            load_val_s = i_LoadVal;
        end
    end

    // Next count: clear > load > step; a step at terminal count wraps or holds.
    always_comb begin
        cnt_nxt_s = cnt_r;
        step_s    = 1'b0;
        if (i_Clr) begin
            cnt_nxt_s = WIDTH'(0);
        end else if (i_Load) begin
            cnt_nxt_s = load_val_s;
        end else if (tick_s) begin
            step_s = 1'b1;
            if (tc_s) begin
                case (mode_s)
                    MODE_SAT:  cnt_nxt_s = cnt_r;
                    MODE_WRAP: cnt_nxt_s = (dir_s == DIR_UP) ? WIDTH'(0) : MAX_CNT;
                    default:   cnt_nxt_s = cnt_r;
                endcase
            end else begin
                case (dir_s)
                    DIR_UP:   cnt_nxt_s = cnt_r + WIDTH'(1);
                    DIR_DOWN: cnt_nxt_s = cnt_r - WIDTH'(1);
                    default:  cnt_nxt_s = cnt_r;
                endcase
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Sticky flag: a step at terminal count sets it and beats a same-cycle clear.
    always_comb begin
        ovf_nxt_s = ovf_r;
        if (step_s && tc_s) begin
            ovf_nxt_s = 1'b1;
        end else if (i_OvfClr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Count, step pulse and flag registers.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            cnt_r  <= WIDTH'(0);
            step_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            step_r <= step_s;
            ovf_r  <= ovf_nxt_s;
        end
    end

    assign o_Cout = cnt_r;
    assign o_Tc   = tc_s;
    assign o_Step = step_r;
    assign o_Ovf  = ovf_r;

endmodule : counter_updown_mod

// File: tb/tb_counter_updown_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_updown_mod
// Directed bench: a WIDTH=4 / MODULO=10 counter with PRESCALE=1 and a second
// instance with PRESCALE=3. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_counter_updown_mod;

    logic       clk;
    // Main instance (PRESCALE=1)
    logic       rst_n;
    logic       clr, en, up, sat, load, ovf_clr;
    logic [3:0] load_val;
    logic [3:0] cout;
    logic       tc, step, ovf;
    // Prescaled instance (PRESCALE=3)
    logic       p_rst_n;
    logic       p_clr, p_en;
    logic [3:0] p_cout;
    logic       p_tc, p_step, p_ovf;

    int n_cmp;
    int n_err;

    counter_updown_mod #(.WIDTH(4), .MODULO(64'd10), .PRESCALE(1)) dut (
        .i_Clk(clk), .i_nRst(rst_n), .i_Clr(clr), .i_En(en), .i_Up(up),
        .i_Sat(sat), .i_Load(load), .i_LoadVal(load_val), .i_OvfClr(ovf_clr),
        .o_Cout(cout), .o_Tc(tc), .o_Step(step), .o_Ovf(ovf)
    );

    counter_updown_mod #(.WIDTH(4), .MODULO(64'd10), .PRESCALE(3)) dut_p (
        .i_Clk(clk), .i_nRst(p_rst_n), .i_Clr(p_clr), .i_En(p_en), .i_Up(1'b1),
        .i_Sat(1'b0), .i_Load(1'b0), .i_LoadVal(4'd0), .i_OvfClr(1'b0),
        .o_Cout(p_cout), .o_Tc(p_tc), .o_Step(p_step), .o_Ovf(p_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    int steps;
    int exp_c;

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; p_rst_n = 1'b0;
        clr = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0;
        ovf_clr = 1'b0; load_val = 4'd0;
        p_clr = 1'b0; p_en = 1'b0;
        cycle(); cycle();
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_step", 32'(step), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_p_cout", 32'(p_cout), 32'd0);
        rst_n = 1'b1; p_rst_n = 1'b1;
        cycle();

        // Up-wrap: 12 enabled cycles -> 1..9,0,1,2
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            exp_c = i % 10;
            check($sformatf("upwrap_cout%0d", i), 32'(cout), 32'(exp_c));
            check($sformatf("upwrap_tc%0d", i), 32'(tc), (exp_c == 9) ? 32'd1 : 32'd0);
            check($sformatf("upwrap_ovf%0d", i), 32'(ovf), (i >= 10) ? 32'd1 : 32'd0);
            check($sformatf("upwrap_step%0d", i), 32'(step), 32'd1);
        end

        // Down-saturate: load 2 (clearing the flag), then 4 down steps
        en = 1'b0; load = 1'b1; load_val = 4'd2; ovf_clr = 1'b1;
        cycle();
        check("ld2_cout", 32'(cout), 32'd2);
        check("ld2_step", 32'(step), 32'd0);
        check("ld2_ovf", 32'(ovf), 32'd0);
        load = 1'b0; ovf_clr = 1'b0; up = 1'b0; sat = 1'b1; en = 1'b1;
        steps = 0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            if (step) steps++;
            check($sformatf("dsat_cout%0d", i), 32'(cout), (i == 1) ? 32'd1 : 32'd0);
            check($sformatf("dsat_ovf%0d", i), 32'(ovf), (i >= 3) ? 32'd1 : 32'd0);
        end
        check("dsat_steps", 32'(steps), 32'd4);
        check("dsat_tc_down", 32'(tc), 32'd1);
        up = 1'b1; #1;
        check("tc_up_at0", 32'(tc), 32'd0);

        // Load clamp, then clear beats load
        en = 1'b0; load = 1'b1; load_val = 4'd14;
        cycle();
        check("clamp_cout", 32'(cout), 32'd9);
        check("clamp_tc", 32'(tc), 32'd1);
        clr = 1'b1; load = 1'b1; load_val = 4'd5;
        cycle();
        check("clrld_cout", 32'(cout), 32'd0);
        check("clrld_step", 32'(step), 32'd0);
        clr = 1'b0;

        // Async reset at count 5, asserted between edges
        load = 1'b1; load_val = 4'd5;
        cycle();
        load = 1'b0;
        check("ld5_cout", 32'(cout), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Wrap with simultaneous flag clear: set wins
        load = 1'b1; load_val = 4'd9; up = 1'b1; sat = 1'b0; en = 1'b0;
        cycle();
        load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
        cycle();
        check("wrapclr_cout", 32'(cout), 32'd0);
        check("wrapclr_ovf", 32'(ovf), 32'd1);
        en = 1'b0;
        cycle();
        check("ovfclr_ovf", 32'(ovf), 32'd0);
        ovf_clr = 1'b0;

        // Prescale 3: 9 enabled cycles -> 3 steps
        p_en = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            check($sformatf("ps_cout%0d", i), 32'(p_cout), 32'(i / 3));
            check($sformatf("ps_step%0d", i), 32'(p_step), ((i % 3) == 0) ? 32'd1 : 32'd0);
        end
        // One enabled, two held, two enabled: step lands 2 cycles late
        for (int i = 1; i <= 5; i++) begin
            p_en = (i == 2 || i == 3) ? 1'b0 : 1'b1;
            cycle();
            check($sformatf("psh_cout%0d", i), 32'(p_cout), (i == 5) ? 32'd4 : 32'd3);
            check($sformatf("psh_step%0d", i), 32'(p_step), (i == 5) ? 32'd1 : 32'd0);
        end
        // Reset mid-prescale discards the partial phase
        p_en = 1'b1;
        cycle();
        p_rst_n = 1'b0;
        #2;
        check("ps_rst_cout", 32'(p_cout), 32'd0);
        @(negedge clk);
        p_rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check($sformatf("psr_cout%0d", i), 32'(p_cout), (i == 3) ? 32'd1 : 32'd0);
        end
        // Clear resets the phase as well as the count
        cycle();
        p_clr = 1'b1;
        cycle();
        p_clr = 1'b0;
        check("psclr_cout", 32'(p_cout), 32'd0);
        cycle(); cycle();
        check("psclr_hold", 32'(p_cout), 32'd0);
        cycle();
        check("psclr_step", 32'(p_cout), 32'd1);
        p_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_counter_updown_mod
